hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller that generates the hold and flush controls consumed by the PC register and the IF/ID and ID/EX pipeline registers.
- Drives the PC hold input: PC loads when hold is low, keeps its value when hold is high.
- Detects load-use hazards, inserts taken-branch flush bubbles, and freezes the front end while data memory is busy.
- Sits beside the ID stage; receives decode, EX and MEM status; all outputs are driven to defined 0/1 values at all times.

Parameters:
REG_W, 5, register-specifier width
BR_PENALTY, 2, total flush cycles per taken branch (legal 1..7)
CNT_W, 16, width of the stall statistics counter

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  synchronous active-high reset
ID_RS  input  REG_W  source reg 1 of instruction in ID
ID_RT  input  REG_W  source reg 2 of instruction in ID
ID_USES_RT  input  1  ID instruction reads RT
EX_MEMREAD  input  1  EX instruction is a load
EX_RT  input  REG_W  load destination in EX
BR_TAKEN  input  1  branch in EX resolved taken (1-cycle pulse)
MEM_BUSY  input  1  data memory not ready; pipeline must freeze
PC_STALL  output  1  to PC hold input: 1 = hold, 0 = load next PC
IFID_STALL  output  1  IF/ID register hold
IDEX_STALL  output  1  ID/EX register hold
IFID_FLUSH  output  1  IF/ID insert bubble
IDEX_FLUSH  output  1  ID/EX insert bubble
STALL_COUNT  output  CNT_W  cycles with PC_STALL=1 (see Optional Feature)

Behaviour:
- All outputs are combinational from the current state plus inputs, so a hazard takes effect in the same cycle it is detected. State updates on the CLK rising edge.
- States: RUN, FLUSH. Internal flush counter fcnt, 3 bits.
- RST=1 at an edge: state=RUN, fcnt=0, statistics counter=0. During reset all control outputs are 0, so PC_STALL=0.
- Priority per cycle: MEM_BUSY > BR_TAKEN / FLUSH > load-use.
- MEM_BUSY=1 (any state):
  - PC_STALL=IFID_STALL=IDEX_STALL=1, both flushes=0.
  - State and fcnt are frozen.
  - BR_TAKEN arriving while busy is ignored; EX is holding, so the source re-asserts it after the freeze.
- RUN, BR_TAKEN=1:
  - IFID_FLUSH=IDEX_FLUSH=1; PC_STALL=0, so the target address loads.
  - If BR_PENALTY>1: go to FLUSH with fcnt=BR_PENALTY-1. Otherwise stay in RUN.
- FLUSH:
  - IFID_FLUSH=IDEX_FLUSH=1 each non-busy cycle; fcnt decrements.
  - When fcnt==1 and not busy, go to RUN.
  - A new BR_TAKEN in FLUSH reloads fcnt=BR_PENALTY-1.
  - Load-use detection is suppressed in FLUSH.
- RUN load-use: hit = EX_MEMREAD & (EX_RT!=0) & ((EX_RT==ID_RS) | (ID_USES_RT & EX_RT==ID_RT)).
  - On hit: PC_STALL=1, IFID_STALL=1, IDEX_FLUSH=1. Exactly one bubble, because the load leaves EX the next cycle.
- Register 0 never causes a hazard.
- No stall and flush to the same register in the same cycle. Stall wins only under MEM_BUSY.
- Reset mid-FLUSH: returns to RUN immediately; no residual flush.

Optional Feature:
HAZ_STATS_EN
- Defined: STALL_COUNT increments on every non-reset edge where PC_STALL=1. It saturates at all-ones and does not wrap. It clears on RST.
- Undefined: STALL_COUNT is tied to 0 and no counter logic is built.

Test Plan:
- Reset: RST=1 for 2 cycles, then release with all inputs 0 -> all controls 0 and STALL_COUNT=0 on the first cycle after release.
- Load-use: EX_MEMREAD=1, EX_RT=5, ID_RS=5 for 1 cycle -> PC_STALL=IFID_STALL=IDEX_FLUSH=1 that cycle only. Same stimulus with EX_RT=0 -> no stall.
- Branch: BR_TAKEN pulse with BR_PENALTY=2 -> flushes high for 2 consecutive cycles, PC_STALL=0 in both, then state=RUN.
- Busy during flush: BR_TAKEN, then MEM_BUSY=1 for 3 cycles starting the next cycle -> 3 cycles of full stall with flushes low, then 1 remaining flush cycle.
- Branch over load-use: BR_TAKEN=1 together with a load-use hit -> flushes only, PC_STALL=0.
- Stats (HAZ_STATS_EN, CNT_W=4): 20 load-use cycles -> STALL_COUNT=15 (saturated); RST -> STALL_COUNT=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline (master: decode/EX/MEM status)
// and hazard_stall_ctrl (slave: returns PC/IF-ID/ID-EX hold and flush controls).
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_RS;
  logic [REG_W-1:0] ID_RT;
  logic             ID_USES_RT;
  logic             EX_MEMREAD;
  logic [REG_W-1:0] EX_RT;
  logic             BR_TAKEN;
  logic             MEM_BUSY;
  logic             PC_STALL;
  logic             IFID_STALL;
  logic             IDEX_STALL;
  logic             IFID_FLUSH;
  logic             IDEX_FLUSH;
  logic [CNT_W-1:0] STALL_COUNT;

  modport master (
    output ID_RS, ID_RT, ID_USES_RT, EX_MEMREAD, EX_RT, BR_TAKEN, MEM_BUSY,
    input  PC_STALL, IFID_STALL, IDEX_STALL, IFID_FLUSH, IDEX_FLUSH, STALL_COUNT
  );
  modport slave (
    input  ID_RS, ID_RT, ID_USES_RT, EX_MEMREAD, EX_RT, BR_TAKEN, MEM_BUSY,
    output PC_STALL, IFID_STALL, IDEX_STALL, IFID_FLUSH, IDEX_FLUSH, STALL_COUNT
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, taken-branch flush and memory-busy freeze controller.
// Define HAZ_STATS_EN to build the saturating PC-stall cycle counter.
module hazard_stall_ctrl #(
  parameter int REG_W      = 5,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input logic                CLK,
  input logic                RST,
  hazard_stall_ctrl_if.slave hz
);
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [2:0]       fcnt, fcnt_nxt;
  logic [REG_W-1:0] ex_rt;
  logic             hit;
  logic             pc_st, ifid_st, idex_st, ifid_fl, idex_fl;

  assign ex_rt = hz.EX_RT;
  assign hit   = hz.EX_MEMREAD && (ex_rt != '0) &&
                 ((ex_rt == hz.ID_RS) || (hz.ID_USES_RT && (ex_rt == hz.ID_RT)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    pc_st     = 1'b0;
    ifid_st   = 1'b0;
    idex_st   = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    if (RST) begin
      state_nxt = RUN;
      fcnt_nxt  = 3'd0;
    end else if (hz.MEM_BUSY) begin
      // Full freeze; a branch seen now is re-presented by EX after the freeze.
      pc_st   = 1'b1;
      ifid_st = 1'b1;
      idex_st = 1'b1;
    end else if (hz.BR_TAKEN) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
      if (BR_PENALTY > 1) begin
        state_nxt = FLUSH;
        fcnt_nxt  = 3'(BR_PENALTY - 1);
      end else begin
        state_nxt = RUN;
        fcnt_nxt  = 3'd0;
      end
    end else if (state == FLUSH) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      fcnt_nxt = fcnt - 3'd1;
      if (fcnt == 3'd1) state_nxt = RUN;
    end else if (hit) begin
      pc_st   = 1'b1;
      ifid_st = 1'b1;
      idex_fl = 1'b1;
    end
  end

  assign hz.PC_STALL   = pc_st;
  assign hz.IFID_STALL = ifid_st;
  assign hz.IDEX_STALL = idex_st;
  assign hz.IFID_FLUSH = ifid_fl;
  assign hz.IDEX_FLUSH = idex_fl;

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge CLK) begin
    if (RST)                              stall_cnt <= '0;
    else if (pc_st && (stall_cnt != '1))  stall_cnt <= stall_cnt + 1'b1;
  end

  assign hz.STALL_COUNT = stall_cnt;
`else
  assign hz.STALL_COUNT = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_hazard_stall_ctrl;
  localparam int REG_W      = 5;
  localparam int BR_PENALTY = 2;
`ifdef HAZ_STATS_EN
  localparam int CNT_W      = 4;
  localparam bit STATS      = 1'b1;
`else
  localparam int CNT_W      = 16;
  localparam bit STATS      = 1'b0;
`endif
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  hazard_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.REG_W(REG_W), .BR_PENALTY(BR_PENALTY), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (bus)
  );

  // exp packs {PC_STALL, IFID_STALL, IDEX_STALL, IFID_FLUSH, IDEX_FLUSH}
  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       use_rt, mrd;
    logic [4:0] ert;
    logic       br, busy;
    logic [4:0] exp;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   m_fl  = 0;   // forced flush cycles still owed after the current one
  int   m_cnt = 0;   // cycles with PC_STALL=1 since reset, saturating
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, int rs, int rt, logic use_rt, logic mrd,
                              int ert, logic br, logic busy, logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.rs = 5'(rs); v.rt = 5'(rt); v.use_rt = use_rt; v.mrd = mrd;
    v.ert = 5'(ert); v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check mid-low-phase, then advance the model.
  task automatic cyc(input vec_t v, input bit use_tbl, input string nm);
    logic [4:0]  e, act;
    logic [31:0] ecnt;
    bit          hit;
    @(negedge CLK);
    RST            = v.rst;
    bus.ID_RS      = v.rs;
    bus.ID_RT      = v.rt;
    bus.ID_USES_RT = v.use_rt;
    bus.EX_MEMREAD = v.mrd;
    bus.EX_RT      = v.ert;
    bus.BR_TAKEN   = v.br;
    bus.MEM_BUSY   = v.busy;
    #1;
    hit = v.mrd && (v.ert != 0) && ((v.ert == v.rs) || (v.use_rt && (v.ert == v.rt)));
    if (v.rst)          e = 5'b00000;
    else if (v.busy)    e = 5'b11100;
    else if (v.br)      e = 5'b00011;
    else if (m_fl > 0)  e = 5'b00011;
    else if (hit)       e = 5'b11001;
    else                e = 5'b00000;
    act = {bus.PC_STALL, bus.IFID_STALL, bus.IDEX_STALL, bus.IFID_FLUSH, bus.IDEX_FLUSH};
    chk({nm, " model"}, 32'(act), 32'(e));
    if (use_tbl) chk(nm, 32'(act), 32'(v.exp));
    ecnt = STATS ? 32'(m_cnt) : 32'd0;
    chk({nm, " stall_count"}, 32'(bus.STALL_COUNT), ecnt);
    if (v.rst) begin
      m_fl  = 0;
      m_cnt = 0;
    end else begin
      if (!v.busy) begin
        if (v.br)          m_fl = BR_PENALTY - 1;
        else if (m_fl > 0) m_fl = m_fl - 1;
      end
      if (e[4] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    vec_t v;
    // Directed table (BR_PENALTY=2), one row per cycle starting in reset.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000)); // reset
    tbl.push_back(mk(1, 5, 0, 0, 1, 5, 1, 0, 5'b00000)); // reset masks everything
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000)); // first idle after release
    tbl.push_back(mk(0, 5, 0, 0, 1, 5, 0, 0, 5'b11001)); // load-use on RS
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000)); // single bubble only
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00000)); // r0 never hazards
    tbl.push_back(mk(0, 3, 7, 1, 1, 7, 0, 0, 5'b11001)); // load-use on RT
    tbl.push_back(mk(0, 3, 7, 0, 1, 7, 0, 0, 5'b00000)); // RT not read
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00011)); // branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00011)); // second flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000)); // back to RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00011)); // branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b11100)); // busy freezes flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b11100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b11100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00011)); // owed flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(0, 9, 0, 0, 1, 9, 1, 0, 5'b00011)); // branch beats load-use
    tbl.push_back(mk(0, 9, 0, 0, 1, 9, 0, 0, 5'b00011)); // load-use suppressed in FLUSH
    tbl.push_back(mk(0, 9, 0, 0, 1, 9, 0, 0, 5'b11001)); // back in RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b11100)); // branch ignored while busy
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00011)); // branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00011)); // re-branch reloads
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00011));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    foreach (tbl[i]) cyc(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Reset mid-flush leaves no residual flush.
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00011), 1'b1, "rst_mid_br");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000), 1'b1, "rst_mid_rst");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000), 1'b1, "rst_mid_after");

    // Saturation: 20 load-use cycles from reset.
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000), 1'b0, "sat_rst");
    for (int i = 0; i < 20; i++)
      cyc(mk(0, 4, 0, 0, 1, 4, 0, 0, 5'b11001), 1'b1, "sat_lu");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000), 1'b0, "sat_idle");
    chk("sat_value", 32'(bus.STALL_COUNT), STATS ? 32'd15 : 32'd0);
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000), 1'b0, "sat_clr_rst");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000), 1'b0, "sat_clr_idle");
    chk("sat_clear", 32'(bus.STALL_COUNT), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 39) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, 5'b00000);
      cyc(v, 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
